// File: rtl/spi_eeprom_fetch.sv
// rtl/spi_eeprom_fetch.sv - SPI EEPROM sequential reader (READ 0x03) feeding a small byte/address buffer.
module spi_eeprom_fetch #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              abort,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_copi,
    input  logic              spi_cipo,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ROOM_LIM = FIFO_DEPTH - 2;

    typedef enum logic [2:0] {IDLE, CMD, ADDRH, ADDRL, DATA, PAUSE, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic [2:0]        bit_cnt;
    logic              push_q;
    logic [7:0]        push_data;
    logic [ADDR_W-1:0] push_addr;
    logic              done_q;

    logic [7:0]        mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W:0]    occupied;
    logic              valid_q;

    logic              flush;
    logic              pop;
    logic              room_ok;
    logic              last_out;
    logic [15:0]       addr_ext;

    assign addr_ext   = 16'(addr);
    assign flush      = abort && (state != IDLE);
    assign pop        = valid_q && byte_ready;
    assign count_next = count + CNT_W'(push_q) - CNT_W'(pop);

    // A byte still waiting in push_q already owns a slot, so it counts as occupied.
    assign occupied   = {1'b0, count} + {{CNT_W{1'b0}}, push_q};
    assign room_ok    = (int'(occupied) <= ROOM_LIM);
    assign last_out   = (state == DRAIN) && pop && (count == CNT_W'(1)) && !push_q && !abort;

    assign byte_valid = valid_q;
    assign byte_data  = mem_data[rd_ptr];
    assign byte_addr  = mem_addr[rd_ptr];
    assign busy       = (state != IDLE);
    assign done       = done_q | last_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            push_addr <= '0;
            done_q    <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            spi_copi  <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            push_q   <= 1'b0;
            done_q   <= 1'b1;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_copi <= 1'b0;
        end else begin
            done_q <= 1'b0;
            push_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= CMD;
                        addr      <= start_addr;
                        last_addr <= end_addr;
                        tx_sh     <= 8'h03;
                        bit_cnt   <= '0;
                    end
                end
                CMD, ADDRH, ADDRL, DATA: begin
                    // First CMD cycle only lowers CS and presents the command MSB.
                    if (spi_cs_n) begin
                        spi_cs_n <= 1'b0;
                        spi_copi <= tx_sh[7];
                    end else if (!spi_sck) begin
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_cipo};
                    end else begin
                        spi_sck <= 1'b0;
                        if (bit_cnt != 3'd7) begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            tx_sh    <= {tx_sh[6:0], 1'b0};
                            spi_copi <= tx_sh[6];
                        end else begin
                            bit_cnt <= '0;
                            case (state)
                                CMD: begin
                                    state    <= ADDRH;
                                    tx_sh    <= addr_ext[15:8];
                                    spi_copi <= addr_ext[15];
                                end
                                ADDRH: begin
                                    state    <= ADDRL;
                                    tx_sh    <= addr_ext[7:0];
                                    spi_copi <= addr_ext[7];
                                end
                                ADDRL: begin
                                    state    <= DATA;
                                    tx_sh    <= '0;
                                    spi_copi <= 1'b0;
                                end
                                default: begin
                                    push_q    <= 1'b1;
                                    push_data <= rx_sh;
                                    push_addr <= addr;
                                    addr      <= addr + 1'b1;
                                    if (addr == last_addr) begin
                                        state    <= DRAIN;
                                        spi_cs_n <= 1'b1;
                                    end else if (!room_ok) begin
                                        state <= PAUSE;
                                    end
                                end
                            endcase
                        end
                    end
                end
                PAUSE: begin
                    if (room_ok) begin
                        state <= DATA;
                    end
                end
                DRAIN: begin
                    if (last_out) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_q) begin
                mem_data[wr_ptr] <= push_data;
                mem_addr[wr_ptr] <= push_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            valid_q <= (count_next != '0);
        end
    end

endmodule

// File: tb/tb_spi_eeprom_fetch.sv
// tb/tb_spi_eeprom_fetch.sv - scoreboard bench for spi_eeprom_fetch with a behavioural SPI EEPROM.
module tb_spi_eeprom_fetch;

    localparam int AW    = 10;
    localparam int ASIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          spi_cs_n;
    logic          spi_sck;
    logic          spi_copi;
    logic          spi_cipo = 1'b0;
    logic [7:0]    byte_data;
    logic [AW-1:0] byte_addr;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic          busy;
    logic          done;

    spi_eeprom_fetch #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .abort(abort), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_copi(spi_copi), .spi_cipo(spi_cipo), .byte_data(byte_data),
        .byte_addr(byte_addr), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } exp_t;

    logic [7:0]    rom [ASIZE];
    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;
    bit            in_abort = 1'b0;
    logic [AW-1:0] cur_start = '0;
    logic [AW-1:0] cur_end = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // byte_ready changes just after the rising edge so the negedge monitor sees it settled.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)      byte_ready = 1'b1;
        else if (ready_mode == 2) byte_ready = ($urandom_range(0, 2) != 0);
        else                      byte_ready = 1'b0;
    end

    // EEPROM: 24 bits of command/address in, then sequential bytes out, changing on falling sck.
    int            bitn = 0;
    logic [23:0]   rxw = '0;
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_ra;
    int            m_bit;

    always @(negedge spi_cs_n) bitn = 0;

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            if (bitn < 24) rxw = {rxw[22:0], spi_copi};
            bitn++;
            if (bitn == 24) begin
                chk("spi_cmd", 32'(rxw[23:16]), 32'h03);
                chk("spi_addr", 32'(rxw[15:0]), 32'(cur_start));
                m_addr = rxw[AW-1:0];
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && bitn >= 24) begin
            m_ra     = m_addr + AW'((bitn - 24) / 8);
            m_bit    = 7 - ((bitn - 24) % 8);
            spi_cipo = rom[m_ra][m_bit];
        end
    end

    logic          prev_hold = 1'b0;
    logic          prev_abort = 1'b0;
    logic [17:0]   prev_word = '0;
    exp_t          e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_byte: got addr %0h data %0h with nothing expected", byte_addr, byte_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_addr", 32'(byte_addr), 32'(e.a));
                    chk("byte_data", 32'(byte_data), 32'(e.d));
                end
            end
            if (prev_hold && !prev_abort) begin
                chk("hold_valid", 32'(byte_valid), 32'd1);
                chk("hold_word", 32'({byte_addr, byte_data}), 32'(prev_word));
            end
            if (done) begin
                done_cnt++;
                if (!in_abort) chk("done_on_last", 32'({byte_valid & byte_ready, byte_addr}), 32'({1'b1, cur_end}));
            end
            prev_hold  = byte_valid && !byte_ready;
            prev_word  = {byte_addr, byte_data};
            prev_abort = abort;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] en);
        logic [AW-1:0] a;
        exp_t x;
        cur_start = s;
        cur_end   = en;
        a = s;
        forever begin
            x.a = a;
            x.d = rom[a];
            exp_q.push_back(x);
            if (a == en) break;
            a = a + 1'b1;
        end
        @(posedge clk);
        #1;
        start_addr = s;
        end_addr   = en;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int tg;
        int hi;
        int d0;
        int len;
        logic ps;
        logic [AW-1:0] s;

        for (int i = 0; i < ASIZE; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33; rom[3] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_copi", 32'(spi_copi), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_word", 32'({byte_addr, byte_data}), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run and first-byte latency.
        ready_mode = 1;
        do_start(10'h000, 10'h003);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (byte_valid) break;
        end
        chk("first_valid_latency", 32'(lat), 32'd66);
        wait_done(2000);

        // Address wrap through zero.
        do_start(10'h3FE, 10'h001);
        wait_done(2000);

        // Consumer stalled: SPI must pause with CS low, then resume losslessly.
        ready_mode = 0;
        do_start(10'h010, 10'h019);
        repeat (250) @(posedge clk);
        tg = 0;
        ps = spi_sck;
        repeat (40) begin
            @(negedge clk);
            if (spi_sck !== ps) tg++;
            ps = spi_sck;
        end
        chk("sck_stalled", 32'(tg), 32'd0);
        chk("cs_held_low", 32'(spi_cs_n), 32'd0);
        chk("stall_head", 32'({byte_valid, byte_addr}), 32'({1'b1, 10'h010}));
        ready_mode = 2;
        wait_done(3000);

        // Abort in the middle of the third data byte.
        ready_mode = 1;
        do_start(10'h100, 10'h10F);
        repeat (88) @(posedge clk);
        #1;
        chk("pre_abort_remaining", 32'(exp_q.size()), 32'd14);
        in_abort = 1'b1;
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sck", 32'(spi_sck), 32'd0);
        chk("abort_valid", 32'(byte_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_done_once", 32'(done_cnt - d0), 32'd1);
        in_abort = 1'b0;
        do_start(10'h120, 10'h122);
        wait_done(2000);

        // Start pulsed while busy must not disturb the run.
        ready_mode = 2;
        do_start(10'h050, 10'h055);
        repeat (30) @(posedge clk);
        #1;
        start_addr = 10'h3A0;
        end_addr   = 10'h3A1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3000);

        // Asynchronous reset during the low address byte.
        ready_mode = 1;
        do_start(10'h200, 10'h20F);
        repeat (40) @(posedge clk);
        #2;
        chk("pre_reset_sck", 32'({spi_cs_n, spi_sck}), 32'b01);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("async_rst_sck", 32'(spi_sck), 32'd0);
        chk("async_rst_outs", 32'({busy, byte_valid, done, spi_copi}), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_cs_n && !busy) hi++;
        end
        chk("no_autostart", 32'(hi), 32'd20);

        // Randomised runs, starting with a single-byte run.
        for (int r = 0; r < 6; r++) begin
            ready_mode = $urandom_range(1, 2);
            s   = AW'($urandom_range(0, ASIZE - 1));
            len = (r == 0) ? 1 : $urandom_range(1, 9);
            do_start(s, s + AW'(len - 1));
            wait_done(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
